// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its issue/writeback stage: opcodes,
// flag bit positions and FSM state encodings.
package alu_pkg;

    localparam logic [5:0] OP_NOP = 6'd0;
    localparam logic [5:0] OP_ADD = 6'd1;
    localparam logic [5:0] OP_SUB = 6'd2;
    localparam logic [5:0] OP_SHL = 6'd3;

    localparam int FLAG_ZERO  = 0;
    localparam int FLAG_NEG   = 1;
    localparam int FLAG_CARRY = 2;
    localparam int FLAG_OVF   = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_LO,
        ST_WAIT_HI,
        ST_WB
    } state_t;

    // State encoding of the ALU itself, kept here so both sides agree.
    typedef enum logic {
        ALU_INIT,
        ALU_WAIT
    } alu_state_t;

    function automatic logic op_is_alu(input logic [5:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SHL);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8x16 register file: two read ports latched on rd_en, one combinational
// debug port, one write port; r0 is never written and reads as zero.
module alu_regfile #(
    parameter int NREGS = 8
) (
    input  logic        clk,
    input  logic        srst,
    input  logic        rd_en,
    input  logic [2:0]  ra,
    input  logic [2:0]  rb,
    output logic [15:0] a_data,
    output logic [15:0] b_data,
    input  logic        we,
    input  logic [2:0]  wa,
    input  logic [15:0] wd,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    logic [15:0]      mem [NREGS];
    logic [NREGS-1:0] wsel;

    generate
        for (genvar gi = 0; gi < NREGS; gi++) begin : g_wsel
            assign wsel[gi] = we && (wa == 3'(gi)) && (gi != 0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
            a_data <= '0;
            b_data <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (wsel[i]) begin
                    mem[i] <= wd;
                end
            end
            if (rd_en) begin
                a_data <= mem[ra];
                b_data <= mem[rb];
            end
        end
    end

    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Issue/writeback stage in front of the ALU: accepts one instruction, launches
// the ALU, waits for the rdy falling-then-rising handshake and writes back.
module alu_issue
    import alu_pkg::*;
#(
    parameter int NREGS   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [5:0]  instr_op,
    input  logic [2:0]  instr_rd,
    input  logic [2:0]  instr_rs1,
    input  logic [2:0]  instr_rs2,
    input  logic        instr_imm_en,
    input  logic [15:0] instr_imm,
    output logic        alu_bgn,
    output logic [5:0]  alu_opcode,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    input  logic [15:0] alu_acc1,
    input  logic [15:0] alu_acc2,
    input  logic        alu_zero,
    input  logic        alu_negative,
    input  logic        alu_carry,
    input  logic        alu_overflow,
    input  logic        alu_rdy,
    output logic [3:0]  flags,
    output logic        done,
    output logic        err,
    input  logic [2:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    localparam int CW = $clog2(TIMEOUT) + 1;

    state_t        state_reg;
    logic [5:0]    opcode_reg;
    logic [2:0]    rd_reg;
    logic          imm_en_reg;
    logic [15:0]   imm_reg;
    logic [CW-1:0] cnt_reg;
    logic [15:0]   acc1_reg;
    logic [15:0]   acc2_reg;
    logic [3:0]    flags_reg;
    logic          bgn_reg;
    logic          done_reg;
    logic          err_reg;
    logic [15:0]   rf_a;
    logic [15:0]   rf_b;
    logic          accept;
    logic          launch;
    logic          expired;

    assign accept  = instr_valid && (state_reg == ST_IDLE);
    assign launch  = accept && op_is_alu(instr_op);
    assign expired = (cnt_reg == CW'(TIMEOUT - 1));

    alu_regfile #(.NREGS(NREGS)) u_regfile (
        .clk      (clk),
        .srst     (rst),
        .rd_en    (launch),
        .ra       (instr_rs1),
        .rb       (instr_rs2),
        .a_data   (rf_a),
        .b_data   (rf_b),
        .we       (state_reg == ST_WB),
        .wa       (rd_reg),
        .wd       (acc1_reg),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            opcode_reg <= '0;
            rd_reg     <= '0;
            imm_en_reg <= 1'b0;
            imm_reg    <= '0;
            cnt_reg    <= '0;
            acc1_reg   <= '0;
            acc2_reg   <= '0;
            flags_reg  <= '0;
            bgn_reg    <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            bgn_reg  <= 1'b0;
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (instr_op == OP_NOP) begin
                            done_reg <= 1'b1;
                        end else if (!op_is_alu(instr_op)) begin
                            err_reg  <= 1'b1;
                            done_reg <= 1'b1;
                        end else begin
                            opcode_reg <= instr_op;
                            rd_reg     <= instr_rd;
                            imm_en_reg <= instr_imm_en;
                            imm_reg    <= instr_imm;
                            bgn_reg    <= 1'b1;
                            state_reg  <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_reg   <= '0;
                    state_reg <= ST_WAIT_LO;
                end
                ST_WAIT_LO, ST_WAIT_HI: begin
                    // Completion on the last allowed cycle still wins over the abort.
                    if (state_reg == ST_WAIT_HI && alu_rdy) begin
                        acc1_reg              <= alu_acc1;
                        acc2_reg              <= alu_acc2;
                        flags_reg[FLAG_ZERO]  <= alu_zero;
                        flags_reg[FLAG_NEG]   <= alu_negative;
                        flags_reg[FLAG_CARRY] <= alu_carry;
                        flags_reg[FLAG_OVF]   <= alu_overflow;
                        done_reg              <= 1'b1;
                        state_reg             <= ST_WB;
                    end else if (expired) begin
                        err_reg   <= 1'b1;
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                        if (state_reg == ST_WAIT_LO && !alu_rdy) begin
                            state_reg <= ST_WAIT_HI;
                        end
                    end
                end
                ST_WB: begin
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign instr_ready = (state_reg == ST_IDLE);
    assign alu_bgn     = bgn_reg;
    assign alu_opcode  = opcode_reg;
    assign alu_a       = rf_a;
    assign alu_b       = imm_en_reg ? imm_reg : rf_b;
    assign flags       = flags_reg;
    assign done        = done_reg;
    assign err         = err_reg;

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Issue/writeback stage directly upstream of the ALU.
- Accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 8x16 register file (or takes an immediate for B).
- Launches the ALU with a one-cycle bgn pulse, waits for the ALU's rdy edge, then writes acc1 back to the destination register and latches the four flags.
- A timeout guards against an ALU that never completes.

Parameters:
- NREGS, 8, register file depth; r0 reads as 0 and ignores writes.
- TIMEOUT, 64, max cycles spent in WAIT_LO plus WAIT_HI before the operation is aborted.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr_valid  in  1  instruction present
- instr_ready  out  1  stage can accept an instruction (high only in IDLE)
- instr_op  in  6  opcode: NOP=0, ADD=1, SUB=2, SHL=3, others illegal
- instr_rd  in  3  destination register
- instr_rs1  in  3  source A register
- instr_rs2  in  3  source B register
- instr_imm_en  in  1  B taken from instr_imm instead of rs2
- instr_imm  in  16  immediate
- alu_bgn  out  1  one-cycle start pulse
- alu_opcode  out  6  held stable from ISSUE until the op completes
- alu_a  out  16  held stable from ISSUE until the op completes
- alu_b  out  16  held stable from ISSUE until the op completes
- alu_acc1  in  16  result
- alu_acc2  in  16  result high word, captured only for debug
- alu_zero, alu_negative, alu_carry, alu_overflow  in  1 each  ALU flags
- alu_rdy  in  1  ALU done level
- flags  out  4  {overflow, carry, negative, zero} from the last completed op
- done  out  1  one-cycle pulse on writeback, NOP completion or abort
- err  out  1  sticky; set on timeout or illegal opcode, cleared only by rst
- dbg_addr  in  3  debug read address
- dbg_data  out  16  combinational register read

Behaviour:
- Reset values:
  - state=IDLE; all registers 0.
  - alu_bgn, alu_opcode, alu_a, alu_b, flags, done, err all 0.
  - instr_ready=1 from the first cycle after reset.
- States and transitions:
  - IDLE: on instr_valid&instr_ready, capture the instruction.
    - NOP: done=1 next cycle, no ALU launch, no writeback, stay IDLE.
    - Opcode >3: err<=1, done=1, stay IDLE.
    - Otherwise: latch a=R[rs1], b=(imm_en ? imm : R[rs2]) and go to ISSUE.
  - ISSUE (1 cycle): alu_bgn=1; go to WAIT_LO.
  - WAIT_LO: wait for alu_rdy==0, the ALU acknowledging the start. On seeing it, go to WAIT_HI.
    - alu_rdy already high from the previous op must not be mistaken for completion.
  - WAIT_HI: on alu_rdy==1, capture acc1/acc2 and flags, go to WB.
  - WB (1 cycle): R[rd]<=acc1 unless rd==0; flags updated; done=1; go to IDLE.
- Latency:
  - Accept at cycle 0, bgn at cycle 1.
  - Writeback occurs 1 cycle after rdy is seen high.
  - Minimum accept-to-done is 4 cycles.
- Timeout:
  - Counter starts at 0 on entering WAIT_LO and increments each cycle in WAIT_LO/WAIT_HI.
  - When it reaches TIMEOUT-1 without completion: err<=1, done=1, no writeback, flags unchanged, go to IDLE.
- Hazards:
  - One instruction is in flight, so there are no data hazards.
  - An operand that is also rd reads the pre-write value.
- Debug read:
  - dbg_data=R[dbg_addr] combinationally; reads during WB return the old value.
- Widths:
  - All values are 16-bit and results are truncated to 16 bits.
  - Only the low 3 bits of the register indices are used.
- Reset mid-operation:
  - Returns to IDLE the next cycle, drops alu_bgn, clears the register file and err.
  - Any later alu_rdy is ignored until a new ISSUE.
- instr_valid while busy is ignored; the instruction is not consumed.

Decomposition:
- Shared package (alu_pkg):
  - Opcode constants NOP/ADD/SUB/SHL (6-bit).
  - Flag bit positions.
  - State encoding for alu_issue.
  - The ALU's own INIT/WAIT state constants move there as well.
- One natural sub-module: alu_regfile.
  - 2 sync-latched read ports plus 1 debug read port, 1 write port, r0 hardwired to 0.

Test Plan:
- rst, then load R1=5, R2=3 through ADD rd=1 rs1=0 imm_en imm=5 and ADD rd=2 rs1=0 imm_en imm=3; SUB rd=3 rs1=1 rs2=2 -> R3=2, flags zero=0, done pulses once per instruction.
- SUB rd=4 rs1=2 rs2=1 (3-5) -> R4=16'hFFFE, negative reflects the ALU flag, err=0.
- SHL rd=5 rs1=1 imm_en imm=2 with the ALU model's rdy delayed 10 cycles -> R5=20, done exactly 1 cycle after rdy rises, alu_a/alu_b stable throughout.
- ALU model that never drops or never raises rdy, TIMEOUT=64 -> err=1 and done after 64 wait cycles, target register unchanged, instr_ready=1 afterwards.
- ADD rd=0 imm=7 -> dbg R0=0. Opcode 6'd9 -> err=1, no bgn. NOP -> done 1 cycle later, no bgn.
- rst asserted in WAIT_HI -> next cycle state IDLE, bgn=0, registers 0; a late rdy pulse causes no writeback.
